// File: rtl/stdp_spike_scheduler_pkg.sv
// Shared types and constants for the STDP spike scheduler slice.
package stdp_sched_pkg;

    localparam int NUM_CH = 16;
    localparam int CH_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        PRESENT
    } sched_state_t;

endpackage

// File: rtl/stdp_spike_scheduler_if.sv
// Valid/ready link from the scheduler to the STDP weight-update unit.
interface stdp_spike_scheduler_if
    import stdp_sched_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic             upd_valid;
    logic             upd_ready;
    logic [WIDTH-1:0] upd_data;
    logic [CH_W-1:0]  upd_ch;

    modport master (
        output upd_valid,
        output upd_data,
        output upd_ch,
        input  upd_ready
    );

    modport slave (
        input  upd_valid,
        input  upd_data,
        input  upd_ch,
        output upd_ready
    );

endinterface

// File: rtl/stdp_spike_scheduler_rr_pick.sv
// Combinational round-robin finder: first set request after ptr, wrapping.
module stdp_rr_pick
    import stdp_sched_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              gnt_any
);

    logic [NUM_CH-1:0] rot;
    logic [CH_W-1:0]   idx;
    logic [CH_W-1:0]   off;

    // Rotate so ptr+1 lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot = '0;
        idx = '0;
        off = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx    = CH_W'(i) + ptr + 1'b1;
            rot[i] = req[idx];
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (rot[NUM_CH-1-i]) begin
                off = CH_W'(NUM_CH - 1 - i);
            end
        end
        gnt_idx = off + ptr + 1'b1;
        gnt_any = |req;
    end

endmodule

// File: rtl/stdp_spike_scheduler.sv
// Round-robin scheduler owning the 16:1 synaptic mux select; latches spikes,
// settles the mux, and hands captured words to the weight-update unit.
module stdp_spike_scheduler
    import stdp_sched_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SAMPLE_DLY = 1,
    parameter int DROP_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [NUM_CH-1:0]          spike_evt,
    output logic [CH_W-1:0]            mux_sel,
    input  logic [WIDTH-1:0]           mux_data,
    stdp_spike_scheduler_if.master     upd,
    output logic [NUM_CH-1:0]          pending,
    output logic                       busy,
    output logic [DROP_W-1:0]          drop_cnt
);

    sched_state_t        state_q, state_d;
    logic [NUM_CH-1:0]   pending_q, pending_d;
    logic [CH_W-1:0]     mux_sel_q, mux_sel_d;
    logic                upd_valid_q, upd_valid_d;
    logic [WIDTH-1:0]    upd_data_q, upd_data_d;
    logic [CH_W-1:0]     upd_ch_q, upd_ch_d;
    logic [DROP_W-1:0]   drop_q, drop_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [3:0]          cnt_q, cnt_d;

    logic                hs;
    logic [CH_W-1:0]     gnt_idx;
    logic                gnt_any;
    logic [NUM_CH-1:0]   clr_mask;
    logic [NUM_CH-1:0]   drop_bits;
    logic [4:0]          drop_inc;
    logic [DROP_W+4:0]   drop_sum;

    assign hs = (state_q == PRESENT) && upd_valid_q && upd.upd_ready;

    stdp_rr_pick u_pick (
        .req     (pending_q),
        .ptr     (ptr_q),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: arbitrate from IDLE, count out the settle time, wait for the handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && gnt_any) state_d = SETTLE;
            SETTLE:  if (cnt_q == 4'd1)     state_d = PRESENT;
            PRESENT: if (hs)                state_d = IDLE;
            default:                        state_d = IDLE;
        endcase
    end

    // Datapath: pending bitmap, drop counter, mux select, capture and pointer update.
    always_comb begin
        pending_d   = pending_q;
        mux_sel_d   = mux_sel_q;
        upd_valid_d = upd_valid_q;
        upd_data_d  = upd_data_q;
        upd_ch_d    = upd_ch_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        drop_inc    = '0;

        // A spike landing on the bit being cleared re-queues it and is not a drop.
        clr_mask  = hs ? (NUM_CH'(1) << upd_ch_q) : '0;
        pending_d = (pending_q & ~clr_mask) | spike_evt;
        drop_bits = spike_evt & pending_q & ~clr_mask;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            drop_inc = drop_inc + {4'b0, drop_bits[i]};
        end
        drop_sum = {5'b0, drop_q} + {{DROP_W{1'b0}}, drop_inc};
        drop_d   = (drop_sum > {5'b0, {DROP_W{1'b1}}}) ? '1 : drop_sum[DROP_W-1:0];

        case (state_q)
            IDLE: begin
                if (enable && gnt_any) begin
                    mux_sel_d = gnt_idx;
                    cnt_d     = 4'(SAMPLE_DLY);
                end
            end
            SETTLE: begin
                if (cnt_q == 4'd1) begin
                    upd_data_d  = mux_data;
                    upd_ch_d    = mux_sel_q;
                    upd_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            PRESENT: begin
                if (hs) begin
                    upd_valid_d = 1'b0;
                    ptr_d       = upd_ch_q;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            mux_sel_q   <= '0;
            upd_valid_q <= 1'b0;
            upd_data_q  <= '0;
            upd_ch_q    <= '0;
            drop_q      <= '0;
            ptr_q       <= '1;
            cnt_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            mux_sel_q   <= mux_sel_d;
            upd_valid_q <= upd_valid_d;
            upd_data_q  <= upd_data_d;
            upd_ch_q    <= upd_ch_d;
            drop_q      <= drop_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mux_sel       = mux_sel_q;
    assign upd.upd_valid = upd_valid_q;
    assign upd.upd_data  = upd_data_q;
    assign upd.upd_ch    = upd_ch_q;
    assign pending       = pending_q;
    assign busy          = (state_q != IDLE);
    assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_stdp_spike_scheduler.sv
// Scoreboard bench for stdp_spike_scheduler: default instance A and a
// SAMPLE_DLY=3 / DROP_W=2 instance B, each with its own mux model.
module tb_stdp_spike_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        a_en, b_en;
    logic [15:0] a_spike, b_spike;
    logic [3:0]  a_sel, b_sel;
    logic [15:0] a_mux, b_mux;
    logic [15:0] a_pend, b_pend;
    logic        a_busy, b_busy;
    logic [7:0]  a_drop;
    logic [1:0]  b_drop;
    logic [15:0] a_mem [16];
    logic [15:0] b_mem [16];

    assign a_mux = a_mem[a_sel];
    assign b_mux = b_mem[b_sel];

    stdp_spike_scheduler_if #(.WIDTH(16)) a_if ();
    stdp_spike_scheduler_if #(.WIDTH(16)) b_if ();

    stdp_spike_scheduler #(.WIDTH(16), .SAMPLE_DLY(1), .DROP_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(a_en), .spike_evt(a_spike),
        .mux_sel(a_sel), .mux_data(a_mux), .upd(a_if),
        .pending(a_pend), .busy(a_busy), .drop_cnt(a_drop)
    );

    stdp_spike_scheduler #(.WIDTH(16), .SAMPLE_DLY(3), .DROP_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(b_en), .spike_evt(b_spike),
        .mux_sel(b_sel), .mux_data(b_mux), .upd(b_if),
        .pending(b_pend), .busy(b_busy), .drop_cnt(b_drop)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard entries are {channel, data}.
    logic [19:0] a_sb [$];
    logic [19:0] b_sb [$];
    logic [19:0] a_e, b_e;

    always @(negedge clk) begin
        if (rst_n && a_if.upd_valid && a_if.upd_ready) begin
            if (a_sb.size() == 0) begin
                check("a_sb_unexpected", 32'd1, 32'd0);
            end else begin
                a_e = a_sb.pop_front();
                check("a_ch", a_if.upd_ch, a_e[19:16]);
                check("a_data", a_if.upd_data, a_e[15:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_if.upd_valid && b_if.upd_ready) begin
            if (b_sb.size() == 0) begin
                check("b_sb_unexpected", 32'd1, 32'd0);
            end else begin
                b_e = b_sb.pop_front();
                check("b_ch", b_if.upd_ch, b_e[19:16]);
                check("b_data", b_if.upd_data, b_e[15:0]);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_valid(input int budget);
        int k = 0;
        while (!a_if.upd_valid && k < budget) begin
            next_cycle();
            k++;
        end
        check("a_valid_timeout", a_if.upd_valid, 1);
    endtask

    task automatic wait_a_idle(input int budget);
        int k = 0;
        while ((a_busy || a_pend != 0) && k < budget) begin
            next_cycle();
            k++;
        end
        check("a_idle_timeout", {a_busy, a_pend}, 0);
    endtask

    task automatic wait_b_idle(input int budget);
        int k = 0;
        while ((b_busy || b_pend != 0) && k < budget) begin
            next_cycle();
            k++;
        end
        check("b_idle_timeout", {b_busy, b_pend}, 0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    logic [15:0] hold;
    int          exp_drop;
    int          b_exp;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_en = 1'b1; b_en = 1'b1;
        a_spike = '0; b_spike = '0;
        a_if.upd_ready = 1'b0;
        b_if.upd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            a_mem[i] = 16'hA000 + 16'(i);
            b_mem[i] = 16'hB100 + 16'(i);
        end
        a_mem[5] = 16'hBEEF;
        exp_drop = 0;

        // Reset values.
        #2;
        check("rst_sel", a_sel, 0);
        check("rst_valid", a_if.upd_valid, 0);
        check("rst_data", a_if.upd_data, 0);
        check("rst_ch", a_if.upd_ch, 0);
        check("rst_pend", a_pend, 0);
        check("rst_busy", a_busy, 0);
        check("rst_drop", a_drop, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single spike on channel 5.
        next_cycle();
        a_if.upd_ready = 1'b1;
        a_spike = 16'h0020;
        a_sb.push_back({4'd5, a_mem[5]});
        @(negedge clk); check("ss_pend_c0", a_pend, 0);
        next_cycle(); a_spike = '0;
        @(negedge clk); check("ss_pend_c1", a_pend, 16'h0020); check("ss_busy_c1", a_busy, 0);
        next_cycle();
        @(negedge clk); check("ss_sel_c2", a_sel, 5); check("ss_valid_c2", a_if.upd_valid, 0);
        next_cycle();
        @(negedge clk); check("ss_valid_c3", a_if.upd_valid, 1);
        check("ss_data_c3", a_if.upd_data, 16'hBEEF); check("ss_ch_c3", a_if.upd_ch, 5);
        next_cycle();
        @(negedge clk); check("ss_pend_c4", a_pend, 0); check("ss_valid_c4", a_if.upd_valid, 0);

        // Round robin from reset pointer.
        next_cycle(); pulse_reset();
        next_cycle();
        a_spike = 16'h8009;
        a_sb.push_back({4'd0, a_mem[0]});
        a_sb.push_back({4'd3, a_mem[3]});
        a_sb.push_back({4'd15, a_mem[15]});
        next_cycle(); a_spike = '0;
        wait_a_idle(40);
        next_cycle();
        a_spike = 16'h0012;
        a_sb.push_back({4'd1, a_mem[1]});
        a_sb.push_back({4'd4, a_mem[4]});
        next_cycle(); a_spike = '0;
        wait_a_idle(40);

        // Backpressure with a changing mux input.
        a_if.upd_ready = 1'b0;
        next_cycle();
        a_spike = 16'h0200;
        hold = a_mem[9];
        a_sb.push_back({4'd9, hold});
        next_cycle(); a_spike = '0;
        wait_a_valid(10);
        for (int i = 0; i < 10; i++) begin
            a_mem[9] = 16'($urandom);
            @(negedge clk);
            check("bp_valid", a_if.upd_valid, 1);
            check("bp_data", a_if.upd_data, hold);
            check("bp_ch", a_if.upd_ch, 9);
            check("bp_sel", a_sel, 9);
            next_cycle();
        end
        a_if.upd_ready = 1'b1;
        next_cycle();
        @(negedge clk); check("bp_done_valid", a_if.upd_valid, 0); check("bp_done_pend", a_pend, 0);
        a_mem[9] = hold;

        // Set wins over clear on channel 7.
        a_if.upd_ready = 1'b0;
        next_cycle();
        a_spike = 16'h0080;
        a_sb.push_back({4'd7, a_mem[7]});
        next_cycle(); a_spike = '0;
        wait_a_valid(10);
        a_spike = 16'h0080;
        a_if.upd_ready = 1'b1;
        a_sb.push_back({4'd7, a_mem[7]});
        next_cycle(); a_spike = '0;
        @(negedge clk);
        check("sw_pend7", a_pend[7], 1);
        check("sw_drop", a_drop, exp_drop);
        wait_a_idle(20);
        check("sw_drop_after", a_drop, exp_drop);

        // Drop on an already-pending channel.
        a_if.upd_ready = 1'b0;
        next_cycle();
        a_spike = 16'h0004;
        a_sb.push_back({4'd2, a_mem[2]});
        next_cycle(); a_spike = '0;
        next_cycle(); a_spike = 16'h0004;
        exp_drop = exp_drop + 1;
        next_cycle(); a_spike = '0;
        @(negedge clk); check("drop_one", a_drop, exp_drop);
        next_cycle();
        a_if.upd_ready = 1'b1;
        wait_a_idle(20);
        check("drop_hold", a_drop, exp_drop);

        // Asynchronous reset while presenting.
        a_if.upd_ready = 1'b0;
        next_cycle();
        a_spike = 16'h0800;
        next_cycle(); a_spike = '0;
        wait_a_valid(10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_drop = 0;
        check("ar_valid", a_if.upd_valid, 0);
        check("ar_data", a_if.upd_data, 0);
        check("ar_ch", a_if.upd_ch, 0);
        check("ar_sel", a_sel, 0);
        check("ar_pend", a_pend, 0);
        check("ar_busy", a_busy, 0);
        check("ar_drop", a_drop, exp_drop);
        #1 rst_n = 1'b1;
        next_cycle();
        @(negedge clk); check("ar_idle_busy", a_busy, 0);

        // Enable gating.
        a_en = 1'b0;
        a_if.upd_ready = 1'b1;
        next_cycle();
        a_spike = 16'h2010;
        a_sb.push_back({4'd4, a_mem[4]});
        a_sb.push_back({4'd13, a_mem[13]});
        next_cycle(); a_spike = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("en_busy_low", a_busy, 0);
            check("en_pend_hold", a_pend, 16'h2010);
            next_cycle();
        end
        a_en = 1'b1;
        @(negedge clk); check("en_busy_same", a_busy, 0);
        next_cycle();
        @(negedge clk); check("en_busy_next", a_busy, 1); check("en_sel", a_sel, 4);
        wait_a_idle(30);

        // SAMPLE_DLY=3 latency on instance B.
        b_if.upd_ready = 1'b1;
        next_cycle();
        b_spike = 16'h0040;
        b_sb.push_back({4'd6, b_mem[6]});
        @(negedge clk); check("b_lat_c0", b_if.upd_valid, 0);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            b_spike = '0;
            @(negedge clk);
            check($sformatf("b_lat_c%0d", c), b_if.upd_valid, (c == 5) ? 1 : 0);
            if (c == 2) check("b_sel_c2", b_sel, 6);
        end
        wait_b_idle(30);

        // Saturating drop counter with DROP_W=2.
        b_if.upd_ready = 1'b0;
        b_exp = 0;
        next_cycle();
        b_spike = 16'h0002;
        b_sb.push_back({4'd1, b_mem[1]});
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            b_spike = 16'h0002;
            @(negedge clk);
            check("b_drop_step", b_drop, b_exp);
            b_exp = (b_exp + 1 > 3) ? 3 : b_exp + 1;
        end
        next_cycle(); b_spike = '0;
        @(negedge clk); check("b_drop_sat", b_drop, b_exp);
        next_cycle();
        b_if.upd_ready = 1'b1;
        wait_b_idle(30);

        next_cycle();
        check("a_sb_left", a_sb.size(), 0);
        check("b_sb_left", b_sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stdp_spike_scheduler.md
Name: stdp_spike_scheduler

Overview:
Round-robin scheduler for the shared 16:1 synaptic-data mux in the STDP learning engine. It latches spike events from 16 channels and picks one pending channel at a time. It drives the mux select, waits for the mux output to settle, then presents the captured word plus its channel index to the downstream STDP weight-update unit over a valid/ready handshake. It is the only owner of the mux select; no other block drives it.

Parameters:
WIDTH, 16, bit width of each mux input/output word
SAMPLE_DLY, 1, cycles mux_sel is held stable before mux_data is captured (legal range 1..15)
DROP_W, 8, width of the saturating dropped-event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  allows new arbitration; an in-flight transaction always completes
spike_evt  input  16  per-channel spike pulse; bit i sets pending[i]
mux_sel  output  4  select to the 16:1 mux
mux_data  input  WIDTH  combinational output of the 16:1 mux
upd_valid  output  1  captured word available to the update unit
upd_ready  input  1  update unit accepts the word
upd_data  output  WIDTH  captured mux word
upd_ch  output  4  channel index of upd_data
pending  output  16  pending-event bitmap
busy  output  1  high in any state other than IDLE
drop_cnt  output  DROP_W  saturating count of spikes lost to an already-pending channel

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, pending=0, mux_sel=0, upd_valid=0, upd_data=0, upd_ch=0, drop_cnt=0, last-served pointer ptr=15, settle counter=0. Deassertion takes effect at the next clk edge.
- Pending set/clear, every edge: pending_next = (pending & ~clr_mask) | spike_evt. clr_mask is the one-hot of upd_ch on a handshake edge, otherwise 0. If a set and a clear hit the same bit on the same edge, the set wins and the channel is re-queued.
- Drop: on each edge, count the bits where spike_evt=1, pending=1 and the bit is not cleared on that edge. drop_cnt adds that count and saturates at 2^DROP_W-1.
- FSM states: IDLE, SETTLE, PRESENT.
- IDLE:
  - If enable=1 and pending!=0, pick the winner: the first set bit searching ptr+1, ptr+2, … mod 16.
  - Register mux_sel=winner, load counter=SAMPLE_DLY, go to SETTLE.
  - Otherwise stay in IDLE. mux_sel holds its last value.
- SETTLE:
  - mux_sel is held stable.
  - When counter==1, capture upd_data<=mux_data and upd_ch<=mux_sel, set upd_valid<=1, go to PRESENT.
  - Otherwise decrement the counter.
- PRESENT:
  - upd_valid, upd_data, upd_ch and mux_sel stay stable until upd_ready=1.
  - On the edge with upd_valid & upd_ready: upd_valid<=0, pending[upd_ch] cleared (subject to the set-wins rule), ptr<=upd_ch, go to IDLE.
- Latency: a spike in cycle 0 gives pending visible in cycle 1 and mux_sel in cycle 2. upd_valid rises in cycle 2+SAMPLE_DLY (cycle 3 at default), assuming the block was idle.
- Throughput: minimum 2+SAMPLE_DLY cycles per event when upd_ready is tied high.
- enable=0 in SETTLE/PRESENT: no effect; the transaction completes. Pending bits keep accumulating while enable=0.
- upd_ready while upd_valid=0: ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package stdp_sched_pkg holds:
  - state enum sched_state_t {IDLE, SETTLE, PRESENT}
  - constant NUM_CH=16
  - constant CH_W=4
- One sub-module, stdp_rr_pick: combinational round-robin priority finder.
  - Inputs: req[15:0], ptr[3:0].
  - Outputs: gnt_idx[3:0], gnt_any.
  - Implemented as a rotate → priority encode → un-rotate.
- The 16:1 mux itself stays outside this block and is instantiated by the parent.

Test Plan:
- Single spike: spike_evt=16'h0020 in cycle 0, upd_ready=1, mux input 5 = 16'hBEEF → mux_sel=5 in cycle 2; upd_valid=1, upd_data=16'hBEEF, upd_ch=5 in cycle 3; pending=0 and ptr=5 afterwards.
- Round robin: from reset, spike_evt=16'h8009 in one cycle → service order 0, 3, 15. Then spike_evt=16'h0012 with ptr=15 → order 1, 4.
- Backpressure: upd_ready=0 for 10 cycles while in PRESENT → upd_valid, upd_data, upd_ch and mux_sel stay constant; changes on mux_data are ignored; the handshake completes on the first upd_ready=1 edge.
- Set wins over clear: spike on channel 7 on the same edge as its handshake → pending[7] stays 1 and channel 7 is served again; drop_cnt stays unchanged.
- Drop/saturation: two spikes on channel 2 while it is pending → drop_cnt=1. With DROP_W=2, five extra drops → drop_cnt saturates at 3.
- Reset and enable:
  - rst_n pulsed low while in PRESENT → all outputs return to reset values immediately, with no clk edge needed.
  - enable=0 with pending!=0 → stays in IDLE with busy=0; service starts the cycle after enable=1.
  - SAMPLE_DLY=3 → upd_valid rises in cycle 5 after the spike.
